// File: rtl/mem_port_arbiter.sv
// Four-port arbiter in front of a synchronous single-port RAM: the CPU has fixed priority,
// ports 1-3 share round-robin, and a starvation override lets a long-waiting port beat the CPU.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [3:0]   we,
  input  logic [47:0]  addr,
  input  logic [123:0] wdata,
  output logic [3:0]   gnt,
  output logic [3:0]   rvalid,
  output logic [30:0]  rdata,
  output logic [11:0]  mem_addr,
  output logic         mem_we,
  output logic [30:0]  mem_wdata,
  input  logic [30:0]  mem_rdata,
  output logic         cpu_stall
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]    last;
  logic [CW-1:0] wait_cnt [1:3];
  logic [3:1]    sat;

  // First candidate found when searching from ptr+1, wrapping 3 -> 1.
  function automatic logic [3:0] rr_pick(input logic [3:1] cand, input logic [1:0] ptr);
    logic [3:0] pick;
    logic [1:0] p;
    pick = '0;
    p    = ptr;
    for (int k = 0; k < 3; k++) begin
      p = (p == 2'd3) ? 2'd1 : p + 2'd1;
      if (pick == '0 && cand[p]) pick[p] = 1'b1;
    end
    return pick;
  endfunction

  always_comb begin
    for (int p = 1; p <= 3; p++) sat[p] = req[p] && (wait_cnt[p] == LIMIT);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (|sat)        gnt = rr_pick(sat, last);
      else if (req[0]) gnt = 4'b0001;
      else             gnt = rr_pick(req[3:1], last);
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    for (int p = 0; p < 4; p++) begin
      if (gnt[p]) begin
        mem_addr  = addr[12*p +: 12];
        mem_we    = we[p];
        mem_wdata = wdata[31*p +: 31];
      end
    end
  end

  assign rdata     = mem_rdata;
  assign cpu_stall = req[0] & ~gnt[0];

  // NOTE: state is updated with non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= '0;
      last   <= 2'd3;
      for (int p = 1; p <= 3; p++) wait_cnt[p] <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (|gnt[3:1]) last <= gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd3);
      for (int p = 1; p <= 3; p++) begin
        if (!req[p] || gnt[p])       wait_cnt[p] <= '0;
        else if (wait_cnt[p] != LIMIT) wait_cnt[p] <= wait_cnt[p] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue/array level model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 8;

  logic         clk, reset;
  logic [3:0]   req, we;
  logic [47:0]  addr;
  logic [123:0] wdata;
  logic [3:0]   gnt, rvalid;
  logic [30:0]  rdata, mem_wdata, mem_rdata;
  logic [11:0]  mem_addr;
  logic         mem_we, cpu_stall;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] init_val(input int a);
    return 31'(a * 7 + 3);
  endfunction

  // Synchronous write-first RAM; untouched words read back their initial pattern.
  logic [30:0] ram [4096];
  bit          ram_wr [4096];
  function automatic logic [30:0] ram_read(input logic [11:0] a);
    return ram_wr[a] ? ram[a] : init_val(int'(a));
  endfunction
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= mem_we ? mem_wdata : ram_read(mem_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model state.
  int          wcnt [4];
  int          last_p;
  int          pend_port;
  logic [30:0] pend_data;
  logic [30:0] shadow [int];
  int          last_win;

  function automatic logic [30:0] shadow_read(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  function automatic int model_winner();
    int w = -1;
    if (reset) return -1;
    for (int k = 0; k < 3; k++) begin
      int p = ((last_p + k) % 3) + 1;
      if (w < 0 && req[p] && wcnt[p] == LIMIT) w = p;
    end
    if (w >= 0) return w;
    if (req[0]) return 0;
    for (int k = 0; k < 3; k++) begin
      int p = ((last_p + k) % 3) + 1;
      if (w < 0 && req[p]) w = p;
    end
    return w;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, return 1ns past the rising edge.
  task automatic cycle();
    int          w;
    logic [3:0]  eg;
    logic        ewe;
    logic [11:0] ea;
    @(negedge clk);
    w   = model_winner();
    eg  = '0;
    ewe = 1'b0;
    ea  = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ewe   = we[w];
      ea    = addr[12*w +: 12];
    end
    check("gnt", gnt, eg);
    check("cpu_stall", cpu_stall, req[0] && w != 0);
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, ea);
    if (ewe) check("mem_wdata", mem_wdata, wdata[31*w +: 31]);
    check("rvalid", rvalid, pend_port >= 0 ? 4'(1 << pend_port) : 4'b0);
    if (pend_port >= 0) check("rdata", rdata, pend_data);

    if (reset) begin
      for (int p = 0; p < 4; p++) wcnt[p] = 0;
      last_p    = 3;
      pend_port = -1;
    end else begin
      pend_port = -1;
      if (w >= 0 && !ewe) begin
        pend_port = w;
        pend_data = shadow_read(int'(ea));
      end
      if (ewe) shadow[int'(ea)] = wdata[31*w +: 31];
      for (int p = 1; p <= 3; p++) begin
        if (!req[p] || w == p) wcnt[p] = 0;
        else if (wcnt[p] < LIMIT) wcnt[p]++;
      end
      if (w >= 1) last_p = w;
    end
    last_win = w;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [11:0] a, input logic [30:0] d);
    req[p]           = r;
    we[p]            = w;
    addr[12*p +: 12] = a;
    wdata[31*p +: 31] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] rr_exp [4];
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int p = 0; p < 4; p++) wcnt[p] = 0;
    last_p = 3; pend_port = -1; pend_data = '0; last_win = -1;
    do_reset();

    // CPU streaming reads of address 5.
    set_port(0, 1'b1, 1'b0, 12'h005, 31'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("cpu_gnt", gnt, 4'b0001);
      if (i > 0) check("cpu_rvalid", rvalid, 4'b0001);
      cycle();
    end
    req = '0;
    #1;
    check("cpu_rvalid_last", rvalid, 4'b0001);
    check("cpu_rdata", rdata, 31'd38);
    cycle();

    // Round-robin among ports 1-3 right after reset.
    do_reset();
    rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    for (int p = 1; p <= 3; p++) set_port(p, 1'b1, 1'b0, 12'(p), 31'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt", gnt, rr_exp[i]);
      cycle();
    end
    req = '0;
    cycle();

    // Starvation override of the CPU by port 2.
    do_reset();
    set_port(0, 1'b1, 1'b0, 12'h001, 31'd0);
    set_port(2, 1'b1, 1'b0, 12'h002, 31'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("starve_gnt", gnt, (i == 8) ? 4'b0100 : 4'b0001);
      if (i == 8) check("starve_stall", cpu_stall, 1'b1);
      cycle();
    end
    req = '0;
    cycle();

    // Write by port 2 then CPU read of the same word on the next cycle.
    set_port(2, 1'b1, 1'b1, 12'h0FF, 31'h1234);
    #1;
    check("wr_gnt", gnt, 4'b0100);
    check("wr_mem_we", mem_we, 1'b1);
    cycle();
    set_port(2, 1'b0, 1'b0, 12'h0, 31'd0);
    set_port(0, 1'b1, 1'b0, 12'h0FF, 31'd0);
    #1;
    check("rd_gnt", gnt, 4'b0001);
    cycle();
    req = '0;
    #1;
    check("wf_rvalid", rvalid, 4'b0001);
    check("wf_rdata", rdata, 31'h1234);
    cycle();

    // Reset arriving one cycle after a granted CPU read, with a write pending.
    set_port(0, 1'b1, 1'b0, 12'h005, 31'd0);
    cycle();
    reset = 1'b1;
    set_port(2, 1'b1, 1'b1, 12'h010, 31'h7777);
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 12'h000);
    cycle();
    reset = 1'b0;
    req   = '0;
    #1;
    check("rst_rvalid", rvalid, 4'b0000);
    check("rst_no_write", ram_read(12'h010), 31'd115);
    cycle();

    // Port 3 requests twice under CPU ownership, then withdraws.
    set_port(0, 1'b1, 1'b0, 12'h001, 31'd0);
    set_port(3, 1'b1, 1'b0, 12'h020, 31'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wd_gnt", gnt, 4'b0001);
      cycle();
    end
    set_port(3, 1'b0, 1'b0, 12'h0, 31'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wd_no_p3", {gnt[3], rvalid[3]}, 2'b00);
      cycle();
    end
    req = '0;
    cycle();

    // Randomized traffic, requesters holding requests until granted or withdrawn.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 4; p++) begin
        if (!req[p] || last_win == p) begin
          set_port(p, $urandom_range(0, 99) < ((p == 0) ? 70 : 35), $urandom_range(0, 2) == 0,
                   12'($urandom_range(0, 15)), 31'($urandom));
        end else if ($urandom_range(0, 99) < 3) begin
          req[p] = 1'b0;
        end
      end
      cycle();
    end
    reset = 1'b0;
    req   = '0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
